// File: rtl/cube_acc_drain.sv
// Tile accumulator for cube results: sums beats per tile, then drains rows as quantized, saturated data.
// Define CUBE_ACC_RELU_EN to clamp negative shifted values to zero before saturation.
//
// state | meaning
// ACCUM | accepting beats, accumulating into the tile sums
// DRAIN | presenting one quantized row per transfer, upstream stalled
module cube_acc_drain #(
  parameter int SIZE    = 8,
  parameter int ACC_WID = 35,
  parameter int SUM_WID = 40,
  parameter int OUT_WID = 16
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [ACC_WID*SIZE*SIZE-1:0]  acc_in,
  input  logic [4:0]                    shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0]                    out_row,
  output logic [OUT_WID*SIZE-1:0]       out_data,
  output logic                          busy
);

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic signed [SUM_WID-1:0] SAT_MAX =
    {{(SUM_WID-OUT_WID+1){1'b0}}, {(OUT_WID-1){1'b1}}};
  localparam logic signed [SUM_WID-1:0] SAT_MIN =
    {{(SUM_WID-OUT_WID+1){1'b1}}, {(OUT_WID-1){1'b0}}};

  state_t                     state_q, state_d;
  logic [2:0]                 row_q, row_d;
  logic [4:0]                 shift_q, shift_d;
  logic signed [SUM_WID-1:0]  sum_q [SIZE][SIZE];
  logic signed [SUM_WID-1:0]  sum_d [SIZE][SIZE];
  logic                       accept, xfer, last_row;

  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign last_row = (row_q == 3'(SIZE-1));

  function automatic logic signed [OUT_WID-1:0] quant(
    input logic signed [SUM_WID-1:0] v,
    input logic [4:0]                sh
  );
    logic signed [SUM_WID-1:0] s;
    s = v >>> sh;
`ifdef CUBE_ACC_RELU_EN
    if (s[SUM_WID-1]) s = '0;
`endif
    if (s > SAT_MAX) s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[OUT_WID-1:0];
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (xfer && last_row)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DRAIN);
    busy      = (state_q == DRAIN);
    out_row   = row_q;
  end

  always_comb begin
    logic [ACC_WID-1:0]        elem;
    logic signed [SUM_WID-1:0] ext;
    elem    = '0;
    ext     = '0;
    sum_d   = sum_q;
    row_d   = row_q;
    shift_d = shift_q;
    if (accept) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          elem        = acc_in[i*SIZE*ACC_WID + j*ACC_WID +: ACC_WID];
          ext         = {{(SUM_WID-ACC_WID){elem[ACC_WID-1]}}, elem};
          sum_d[i][j] = in_first ? ext : sum_q[i][j] + ext;
        end
      end
      if (in_last) begin
        shift_d = shift;
        row_d   = '0;
      end
    end
    if (xfer) begin
      if (last_row) begin
        row_d = '0;
        // Clearing here lets the next tile start with a non-first beat.
        for (int i = 0; i < SIZE; i++)
          for (int j = 0; j < SIZE; j++)
            sum_d[i][j] = '0;
      end else begin
        row_d = row_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      shift_q <= '0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          sum_q[i][j] <= '0;
    end else begin
      row_q   <= row_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < SIZE; j++)
        out_data[j*OUT_WID +: OUT_WID] = quant(sum_q[row_q][j], shift_q);
    end
  end

endmodule

// File: doc/cube_acc_drain.md
CUBE_ACC_DRAIN -- requirements
Module: cube_acc_drain

Interface
REQ-001 SHALL have parameter SIZE, default 8, the cube edge (elements per row and rows per tile).
REQ-002 SHALL have parameter ACC_WID, default 35, the width of each signed element of acc_in.
REQ-003 SHALL have parameter SUM_WID, default 40, the width of each signed internal accumulator.
REQ-004 SHALL have parameter OUT_WID, default 16, the width of each signed quantized output element.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: acc_in carries a cube result.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a result this cycle.
REQ-009 SHALL have port in_first, input, 1 bit: beat starts a tile (overwrite, not add).
REQ-010 SHALL have port in_last, input, 1 bit: beat ends a tile and triggers drain.
REQ-011 SHALL have port acc_in, input, ACC_WID*SIZE*SIZE bits: element [i][j] at bits i*SIZE*ACC_WID + j*ACC_WID, width ACC_WID.
REQ-012 SHALL have port shift, input, 5 bits: quantization right-shift, sampled on the in_last beat.
REQ-013 SHALL have port out_valid, output, 1 bit: a row is presented.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream takes the row.
REQ-015 SHALL have port out_row, output, 3 bits: row index 0..SIZE-1 of out_data.
REQ-016 SHALL have port out_data, output, OUT_WID*SIZE bits: element j at bits j*OUT_WID, width OUT_WID.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is DRAIN.

Function
REQ-018 SHALL implement two states, ACCUM and DRAIN; in_ready = 1 in ACCUM and 0 in DRAIN.
REQ-019 SHALL accept a beat when in_valid && in_ready; each element is sign-extended to SUM_WID, then written (in_first=1) or added, wrapping modulo 2^SUM_WID (in_first=0).
REQ-020 SHALL, on an accepted beat with in_last=1, register shift, go to DRAIN next cycle, and set row counter to 0; in_first=in_last=1 is a valid single-pass tile.
REQ-021 SHALL in DRAIN hold out_valid=1 with out_row = row counter; out_data elements = sat(sum[row][j] >>> shift), arithmetic shift, clipped to [-2^(OUT_WID-1), 2^(OUT_WID-1)-1].
REQ-022 SHALL, on out_valid && out_ready, advance the row; rows emerge in order 0..SIZE-1, and out_row/out_data hold stable while out_ready=0.
REQ-023 SHALL, on transfer of row SIZE-1, clear all accumulators to 0 and return to ACCUM, with in_ready=1 the next cycle.
REQ-024 SHALL raise out_valid one cycle after the in_last beat is accepted; with out_ready held at 1, a drain takes exactly SIZE cycles.
REQ-025 SHALL ignore in_valid while in DRAIN; an upstream stage holds its beat until in_ready=1.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-drain, immediately force: state ACCUM, all accumulators 0, row counter 0, registered shift 0, out_valid 0, out_row 0, out_data 0, busy 0, in_ready 1.

Configuration
REQ-027 SHALL, when macro CUBE_ACC_RELU_EN is defined, clamp negative shifted values to 0 before saturation; when undefined, pass negative values through to saturation unchanged.

Verification
REQ-028 SHALL pass this scenario: single pass (first=last=1), all elements 100, shift 0, out_ready=1 -> 8 consecutive rows, out_row 0..7, every element 100, then in_ready=1.
REQ-029 SHALL pass this scenario: 3 beats (first, -, last), all elements 1000, shift 2 -> every output element 750.
REQ-030 SHALL pass this scenario: single pass, element [0][0]=2^20 and [0][1]=-2^20, shift 0 -> row 0 elements 32767 and -32768.
REQ-031 SHALL pass this scenario: out_ready=0 for 3 cycles while out_row=3 -> out_row/out_data stable, in_ready stays 0, row 4 follows the release.
REQ-032 SHALL pass this scenario: rst_n pulsed low during row 4 -> out_valid 0 at once, in_ready 1, and a new non-first beat of 5 yields 5 (accumulators cleared).
REQ-033 SHALL pass this scenario: elements -500, shift 0 -> 0 with CUBE_ACC_RELU_EN defined, -500 without.
